// File: rtl/link_watchdog.sv
// ============================================================================
//  Module      : link_watchdog
//  Description : Passive monitor for a credit-based NoC link. Tracks in-packet
//                stalls, declares a hang after HANG_THRESHOLD stall cycles and
//                keeps hang and packet statistics.
//                Optional macro LINK_WATCHDOG_LOG_EN enables hang log messages.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module link_watchdog #(
    parameter logic [15:0] ADDRESS        = 16'b0,
    parameter string       PORT           = "",
    parameter int          HANG_THRESHOLD = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    input  logic        cr_rx_i,
    input  logic        eop_rx_i,
    output logic        hang_o,
    output logic        hang_active_o,
    output logic [15:0] hang_len_o,
    output logic [31:0] hang_cnt_o,
    output logic [31:0] pkt_cnt_o
);

    localparam int          c_THRESH   = (HANG_THRESHOLD == 0) ? 1 : HANG_THRESHOLD;
    localparam logic [31:0] c_THRESH_U = 32'(c_THRESH);
    localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;
    localparam logic [31:0] c_STAT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        STALL   = 2'd2,
        HANGED  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_stall_cnt;
    logic [15:0] w_stall_cnt_next;
    logic [15:0] w_stall_cnt_inc;
    logic        w_xfer;
    logic        w_pkt_end;
    logic        w_len_load;
    logic        w_hang_enter;

    logic        r_hang;
    logic        r_hang_active;
    logic [15:0] r_hang_len;
    logic [31:0] r_hang_cnt;
    logic [31:0] r_pkt_cnt;

    // Identification parameters only feed the optional log messages.
    logic        w_unused_id;
    assign w_unused_id = ^{ADDRESS, (PORT == "")};

    assign w_xfer          = rx_i & cr_rx_i;
    assign w_pkt_end       = w_xfer & eop_rx_i;
    assign w_stall_cnt_inc = (r_stall_cnt == c_CNT_MAX) ? r_stall_cnt : r_stall_cnt + 16'd1;

    always_comb begin
        w_state_next     = r_state;
        w_stall_cnt_next = r_stall_cnt;
        w_len_load       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_next = eop_rx_i ? IDLE : PAYLOAD;
                end else if (rx_i) begin
                    w_state_next     = STALL;
                    w_stall_cnt_next = 16'd1;
                end
            end
            PAYLOAD: begin
                if (w_xfer) begin
                    w_state_next = eop_rx_i ? IDLE : PAYLOAD;
                end else begin
                    w_state_next     = STALL;
                    w_stall_cnt_next = 16'd1;
                end
            end
            STALL: begin
                if (w_xfer) begin
                    w_state_next     = eop_rx_i ? IDLE : PAYLOAD;
                    w_stall_cnt_next = 16'd0;
                end else begin
                    w_stall_cnt_next = w_stall_cnt_inc;
                end
            end
            HANGED: begin
                if (w_xfer) begin
                    w_state_next     = eop_rx_i ? IDLE : PAYLOAD;
                    w_stall_cnt_next = 16'd0;
                    w_len_load       = 1'b1;
                end else begin
                    w_stall_cnt_next = w_stall_cnt_inc;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_stall_cnt_next = 16'd0;
            end
        endcase

        // Threshold check also covers stall entry, so a threshold of 1 hangs
        // on the very first stall cycle.
        if ((w_state_next == STALL) && ({16'd0, w_stall_cnt_next} == c_THRESH_U)) begin
            w_state_next = HANGED;
        end
    end

    assign w_hang_enter = (w_state_next == HANGED) && (r_state != HANGED);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_stall_cnt   <= 16'd0;
            r_hang        <= 1'b0;
            r_hang_active <= 1'b0;
            r_hang_len    <= 16'd0;
            r_hang_cnt    <= 32'd0;
            r_pkt_cnt     <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_stall_cnt   <= w_stall_cnt_next;
            r_hang        <= w_hang_enter;
            r_hang_active <= (w_state_next == HANGED);
            if (w_len_load) begin
                r_hang_len <= r_stall_cnt;
            end
            if (w_hang_enter && (r_hang_cnt != c_STAT_MAX)) begin
                r_hang_cnt <= r_hang_cnt + 32'd1;
            end
            if (w_pkt_end && (r_pkt_cnt != c_STAT_MAX)) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign hang_o        = r_hang;
    assign hang_active_o = r_hang_active;
    assign hang_len_o    = r_hang_len;
    assign hang_cnt_o    = r_hang_cnt;
    assign pkt_cnt_o     = r_pkt_cnt;

`ifdef LINK_WATCHDOG_LOG_EN
    always_ff @(posedge clk_i) begin
        if (rst_ni && r_hang) begin
            $display("[%7.3f ms] [WD %02hx%02h-%s] Hang detected",
                     $time / 1_000_000.0, ADDRESS[15:8], ADDRESS[7:0], PORT);
        end
        if (rst_ni && (r_state == HANGED) && w_xfer) begin
            $display("[%7.3f ms] [WD %02hx%02h-%s] Hang released after %0d cycles",
                     $time / 1_000_000.0, ADDRESS[15:8], ADDRESS[7:0], PORT, r_stall_cnt);
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_link_watchdog.sv
// ============================================================================
//  Module      : tb_link_watchdog
//  Description : Directed self-checking bench for link_watchdog (thresholds
//                4 and 0 instantiated side by side on shared stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_link_watchdog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        cr;
    logic        eop;

    logic        hang_a, active_a;
    logic [15:0] len_a;
    logic [31:0] hcnt_a, pcnt_a;
    logic        hang_b, active_b;
    logic [15:0] len_b;
    logic [31:0] hcnt_b, pcnt_b;

    int checks   = 0;
    int failures = 0;
    int pulses_a = 0;

    always #5 clk = ~clk;

    link_watchdog #(.ADDRESS(16'h0102), .PORT("E"), .HANG_THRESHOLD(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .cr_rx_i(cr), .eop_rx_i(eop),
        .hang_o(hang_a), .hang_active_o(active_a), .hang_len_o(len_a),
        .hang_cnt_o(hcnt_a), .pkt_cnt_o(pcnt_a)
    );

    link_watchdog #(.ADDRESS(16'h0304), .PORT("W"), .HANG_THRESHOLD(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .cr_rx_i(cr), .eop_rx_i(eop),
        .hang_o(hang_b), .hang_active_o(active_b), .hang_len_o(len_b),
        .hang_cnt_o(hcnt_b), .pkt_cnt_o(pcnt_b)
    );

    always @(negedge clk) begin
        if (hang_a) pulses_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic e);
        rx  = r;
        cr  = c;
        eop = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx    = 1'b0;
        cr    = 1'b0;
        eop   = 1'b0;
        #3;
        chk("rst_hang",   {31'd0, hang_a},   32'd0);
        chk("rst_active", {31'd0, active_a}, 32'd0);
        chk("rst_len",    {16'd0, len_a},    32'd0);
        chk("rst_hcnt",   hcnt_a,            32'd0);
        chk("rst_pcnt",   pcnt_a,            32'd0);
        rst_n = 1'b1;

        // 3-flit packet, credit always present
        cyc(1, 1, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        chk("clean_pcnt",   pcnt_a,   32'd1);
        chk("clean_hcnt",   hcnt_a,   32'd0);
        chk("clean_pulses", pulses_a, 32'd0);

        // 3-cycle credit stall below threshold, then resume
        cyc(1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        chk("short_active", {31'd0, active_a}, 32'd0);
        cyc(1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0);
        cyc(1, 1, 1);
        chk("short_pcnt",   pcnt_a,   32'd2);
        chk("short_hcnt",   hcnt_a,   32'd0);
        chk("short_pulses", pulses_a, 32'd0);

        // 10-cycle stall: hang_o on the 4th stall cycle's result
        cyc(1, 1, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("hang_o_%0d", i),   {31'd0, hang_a},   {31'd0, (i == 4)});
            chk($sformatf("active_%0d", i),   {31'd0, active_a}, {31'd0, (i >= 4)});
        end
        chk("hang10_hcnt", hcnt_a, 32'd1);
        cyc(1, 1, 1);
        chk("hang10_len",    {16'd0, len_a},    32'd10);
        chk("hang10_active", {31'd0, active_a}, 32'd0);
        chk("hang10_hcnt2",  hcnt_a,            32'd1);
        chk("hang10_pcnt",   pcnt_a,            32'd3);
        chk("hang10_pulses", pulses_a,          32'd1);

        // 70000-cycle stall saturates the stall length
        cyc(1, 1, 0);
        for (int i = 0; i < 70000; i++) cyc(0, 0, 0);
        cyc(1, 1, 1);
        chk("sat_len",    {16'd0, len_a}, 32'd65535);
        chk("sat_pulses", pulses_a,       32'd2);
        chk("sat_hcnt",   hcnt_a,         32'd2);
        chk("sat_pcnt",   pcnt_a,         32'd4);

        // reset during HANGED clears outputs without a clock edge
        cyc(1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        chk("pre_rst_active", {31'd0, active_a}, 32'd1);
        chk("pre_rst_hcnt",   hcnt_a,            32'd3);
        rst_n = 1'b0;
        #2;
        chk("async_active", {31'd0, active_a}, 32'd0);
        chk("async_len",    {16'd0, len_a},    32'd0);
        chk("async_hcnt",   hcnt_a,            32'd0);
        chk("async_pcnt",   pcnt_a,            32'd0);
        rst_n = 1'b1;
        cyc(1, 1, 1);
        chk("post_rst_pcnt",   pcnt_a,            32'd1);
        chk("post_rst_active", {31'd0, active_a}, 32'd0);

        // stall at packet start (rx without credit from IDLE)
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 0);
            chk($sformatf("idle_hang_%0d", i), {31'd0, hang_a}, {31'd0, (i == 4)});
        end
        cyc(1, 1, 1);
        chk("idle_len",  {16'd0, len_a}, 32'd4);
        chk("idle_pcnt", pcnt_a,         32'd2);

        // threshold 0 behaves as 1: first stall cycle hangs
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        cyc(1, 1, 0);
        cyc(0, 0, 0);
        chk("th0_hang",   {31'd0, hang_b},   32'd1);
        chk("th0_active", {31'd0, active_b}, 32'd1);
        chk("th0_hcnt",   hcnt_b,            32'd1);
        chk("th4_nohang", {31'd0, hang_a},   32'd0);
        cyc(0, 0, 0);
        chk("th0_pulse_end", {31'd0, hang_b}, 32'd0);
        cyc(1, 1, 1);
        chk("th0_len",  {16'd0, len_b}, 32'd2);
        chk("th0_pcnt", pcnt_b,         32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/link_watchdog.md
LINK_WATCHDOG -- requirements
Module: link_watchdog

Interface
REQ-001 The block SHALL have parameter ADDRESS, default 16'b0, meaning router address of the monitored link ([15:8]=X, [7:0]=Y).
REQ-002 The block SHALL have parameter PORT, default "", meaning port name string of the monitored link.
REQ-003 The block SHALL have parameter HANG_THRESHOLD, default 32, meaning consecutive in-packet stall cycles that declare a hang; a value of 0 SHALL be treated as 1.
REQ-004 The block SHALL have port clk_i, input, 1, the single clock.
REQ-005 The block SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port rx_i, input, 1, flit valid on the monitored link.
REQ-007 The block SHALL have port cr_rx_i, input, 1, credit (ready) from the link receiver.
REQ-008 The block SHALL have port eop_rx_i, input, 1, end-of-packet qualifier for the current flit.
REQ-009 The block SHALL have port hang_o, output, 1, one-cycle pulse on hang detection.
REQ-010 The block SHALL have port hang_active_o, output, 1, high while a declared hang persists.
REQ-011 The block SHALL have port hang_len_o, output, 16, stall length of the most recent completed hang.
REQ-012 The block SHALL have port hang_cnt_o, output, 32, number of hangs declared.
REQ-013 The block SHALL have port pkt_cnt_o, output, 32, number of packets completed.

Function
REQ-014 A transfer SHALL be a cycle with rx_i && cr_rx_i, and packet end SHALL be a transfer with eop_rx_i.
REQ-015 The FSM SHALL have states IDLE, PAYLOAD, STALL, HANGED, and all state registers SHALL update on posedge clk_i.
REQ-016 In IDLE: packet end SHALL stay in IDLE; transfer without eop SHALL go to PAYLOAD; rx_i && !cr_rx_i SHALL go to STALL with stall count 1; otherwise the FSM SHALL stay in IDLE.
REQ-017 In PAYLOAD: packet end SHALL go to IDLE; transfer without eop SHALL stay in PAYLOAD; any cycle without a transfer SHALL go to STALL with stall count 1.
REQ-018 In STALL: each non-transfer cycle SHALL increment the 16-bit stall count, saturating at 65535.
REQ-019 In STALL: a transfer SHALL clear the stall count and go to IDLE on packet end, otherwise to PAYLOAD.
REQ-020 In STALL: when the incremented count equals HANG_THRESHOLD, the next state SHALL be HANGED.
REQ-021 On entry to HANGED: hang_o SHALL pulse for exactly one cycle (the first cycle in HANGED) and hang_cnt_o SHALL increment, saturating at 2^32-1.
REQ-022 hang_active_o SHALL equal (state == HANGED), registered.
REQ-023 In HANGED: non-transfer cycles SHALL keep incrementing the stall count (saturating).
REQ-024 In HANGED: a transfer SHALL load hang_len_o with the final stall count, clear the count, and go to IDLE on packet end, otherwise to PAYLOAD.
REQ-025 pkt_cnt_o SHALL increment, saturating, on every packet end in any state.
REQ-026 Packet end in the same cycle as threshold reach cannot occur, because a transfer SHALL always take precedence over stall counting.
REQ-027 The block SHALL be a passive monitor: it SHALL drive no link signals.

Reset
REQ-028 On rst_ni low, asynchronously: state SHALL be IDLE; the stall count SHALL be 0; hang_o, hang_active_o, hang_len_o, hang_cnt_o and pkt_cnt_o SHALL all be 0.
REQ-029 A reset mid-packet or mid-hang SHALL discard that packet; after rst_ni rises, the next rx_i SHALL be treated as a packet start.

Configuration
REQ-030 With macro LINK_WATCHDOG_LOG_EN defined, the block SHALL $display "[time ms] [WD XXxYY-PORT] Hang detected" on hang_o.
REQ-031 With LINK_WATCHDOG_LOG_EN defined, the block SHALL $display "... Hang released after N cycles" when leaving HANGED, where time is $time()/1_000_000.0 formatted %7.3f.
REQ-032 Without LINK_WATCHDOG_LOG_EN, no display code SHALL be compiled and behaviour SHALL be otherwise identical.

Verification
REQ-033 THRESHOLD=4; 3-flit packet with cr_rx_i always 1 -> pkt_cnt_o=1, hang_cnt_o=0, hang_o never high.
REQ-034 THRESHOLD=4; mid-packet cr_rx_i=0 for 3 cycles then resume -> no hang_o, state returns to PAYLOAD, packet completes, pkt_cnt_o=1.
REQ-035 THRESHOLD=4; mid-packet rx_i=0 and cr_rx_i=0 for 10 cycles -> hang_o pulses once, 4 cycles after stall start; hang_active_o high until the transfer; hang_len_o=10; hang_cnt_o=1.
REQ-036 Stall of 70000 cycles -> hang_len_o=65535 (saturated), single hang_o pulse.
REQ-037 Reset asserted during HANGED -> all outputs 0 immediately, without waiting for a clock; next 1-flit eop packet -> pkt_cnt_o=1.
REQ-038 THRESHOLD=0; one stall cycle -> hang declared exactly as for THRESHOLD=1.
